// File: rtl/cadence_pkg.sv
// Shared types and constants for the pedal-cadence generator.
// Bounce constants are only referenced when CADENCE_BOUNCE_EN is defined.
package cadence_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [15:0] TICK_TERM_FAST = 16'd511;
    localparam logic [15:0] TICK_TERM_SLOW = 16'd65535;

    localparam logic [5:0]  BNC_LEN = 6'd48;
    localparam int          BNC_BIT = 3;

    // A programmed half-period of zero behaves like one tick.
    function automatic logic [15:0] eff_period(input logic [15:0] per);
        return (per == 16'd0) ? 16'd1 : per;
    endfunction

endpackage

// File: rtl/cadence_tick.sv
// Tick prescaler: emits a 1-clk pulse every 512 (FAST_SIM=1) or 65536 clocks
// while run is high; held cleared while run is low.
module cadence_tick
    import cadence_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] TERM = (FAST_SIM != 0) ? TICK_TERM_FAST : TICK_TERM_SLOW;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == TERM);

endmodule

// File: rtl/cadence_gen.sv
// Pedal-cadence generator: square wave with per-revolution half-period and
// revolution counter. Define CADENCE_BOUNCE_EN to add sensor bounce on cadence.
module cadence_gen
    import cadence_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] cad_per,
    output logic        cadence,
    output logic        cadence_clean,
    output logic [7:0]  rev_cnt,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] per_q, per_d;
    logic [15:0] phase_q, phase_d;
    logic        clean_q, clean_d;
    logic        busy_q, busy_d;
    logic        cad_q, cad_d;
    logic [7:0]  rev_cnt_q, rev_cnt_d;
    logic        tick;
    logic        phase_done;
`ifdef CADENCE_BOUNCE_EN
    logic [5:0]  bnc_q, bnc_d;
`endif

    cadence_tick #(
        .FAST_SIM(FAST_SIM)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (busy_q),
        .tick (tick)
    );

    assign phase_done = tick && (phase_q == (eff_period(per_q) - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            per_q     <= '0;
            phase_q   <= '0;
            clean_q   <= 1'b0;
            busy_q    <= 1'b0;
            cad_q     <= 1'b0;
            rev_cnt_q <= '0;
`ifdef CADENCE_BOUNCE_EN
            bnc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            phase_q   <= phase_d;
            clean_q   <= clean_d;
            busy_q    <= busy_d;
            cad_q     <= cad_d;
            rev_cnt_q <= rev_cnt_d;
`ifdef CADENCE_BOUNCE_EN
            bnc_q     <= bnc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        phase_d = phase_q;
        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (en) begin
                    state_d = HIGH;
                    per_d   = cad_per;
                end
            end
            HIGH: begin
                if (tick) begin
                    phase_d = phase_q + 16'd1;
                end
                if (phase_done) begin
                    state_d = LOW;
                    phase_d = '0;
                end
            end
            LOW: begin
                if (tick) begin
                    phase_d = phase_q + 16'd1;
                end
                // en is only consulted here, so a revolution always completes.
                if (phase_done) begin
                    phase_d = '0;
                    if (en) begin
                        state_d = HIGH;
                        per_d   = cad_per;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they register on the same edge.
    always_comb begin
        clean_d   = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
        rev_cnt_d = rev_cnt_q + {7'd0, (clean_d & ~clean_q)};
`ifdef CADENCE_BOUNCE_EN
        bnc_d = bnc_q;
        if (clean_d != clean_q) begin
            bnc_d = '0;
        end else if (busy_d && (bnc_q < BNC_LEN)) begin
            bnc_d = bnc_q + 6'd1;
        end
        cad_d = (bnc_d < BNC_LEN) ? (clean_d ^ bnc_d[BNC_BIT]) : clean_d;
`else
        cad_d = clean_d;
`endif
    end

    assign cadence       = cad_q;
    assign cadence_clean = clean_q;
    assign busy          = busy_q;
    assign rev_cnt       = rev_cnt_q;

endmodule

// File: tb/tb_cadence_gen.sv
// Directed bench for cadence_gen at FAST_SIM=1; expectations follow
// CADENCE_BOUNCE_EN when it is defined for the build.
module tb_cadence_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] cad_per;
    logic        cadence;
    logic        cadence_clean;
    logic [7:0]  rev_cnt;
    logic        busy;

    cadence_gen #(
        .FAST_SIM(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cad_per      (cad_per),
        .cadence      (cadence),
        .cadence_clean(cadence_clean),
        .rev_cnt      (rev_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef CADENCE_BOUNCE_EN
    localparam int EXP_TOG = 6;
`else
    localparam int EXP_TOG = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts clocks until the chosen output reaches val; 5000 caps a stuck DUT.
    task automatic wait_for(input bit on_busy, input logic val, output int n);
        n = 0;
        while (((on_busy ? busy : cadence_clean) !== val) && (n < 5000)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Edge-relative bounce monitor and a 512-clk stability filter fed by cadence.
    logic clean_prev = 1'b0;
    logic cad_prev   = 1'b0;
    bit   seen_edge  = 1'b0;
    int   since      = 0;
    int   ntog       = 0;
    int   nbad       = 0;
    logic filt       = 1'b0;
    int   stab       = 0;
    int   ftr        = 0;
    bit   fwin       = 1'b0;
    bit   fedge_prev = 1'b0;

    always @(negedge clk) begin
        if (cadence !== filt) begin
            stab++;
            if (stab >= 512) begin
                filt = cadence;
                stab = 0;
                ftr++;
            end
        end else begin
            stab = 0;
        end

        if (cadence_clean !== clean_prev) begin
            if (seen_edge) begin
                chk("bounce toggles per phase", ntog, EXP_TOG);
                chk("bounce misplaced toggles", nbad, 0);
            end
            if (fwin && fedge_prev) begin
                chk("F filter transitions per edge", ftr, 1);
            end
            fedge_prev = fwin;
            ftr        = 0;
            seen_edge  = 1'b1;
            since      = 0;
            ntog       = 0;
            nbad       = (cadence !== cadence_clean) ? 1 : 0;
        end else begin
            since++;
            if (cadence !== cad_prev) begin
                ntog++;
                if (!((since >= 8) && (since <= 48) && ((since % 8) == 0))) begin
                    nbad++;
                end
            end
        end
        clean_prev = cadence_clean;
        cad_prev   = cadence;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int lo;
        int n;

        rst_n   = 1'b0;
        en      = 1'b0;
        cad_per = 16'd0;
        #1;
        chk("reset cadence", cadence, 0);
        chk("reset cadence_clean", cadence_clean, 0);
        chk("reset busy", busy, 0);
        chk("reset rev_cnt", rev_cnt, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        chk("idle busy", busy, 0);

        // A: cad_per=2, en held
        cad_per = 16'd2;
        en      = 1'b1;
        cycles(1);
        chk("A first edge clean", cadence_clean, 1);
        chk("A first edge busy", busy, 1);
        chk("A first edge rev", rev_cnt, 1);
        chk("A first edge cadence", cadence, 1);
        wait_for(1'b0, 1'b0, hi);
        chk("A high length", hi, 1024);
        chk("A rev during low", rev_cnt, 1);
        wait_for(1'b0, 1'b1, lo);
        chk("A low length", lo, 1024);
        chk("A period", hi + lo, 2048);
        chk("A rev at 2048", rev_cnt, 2);
        en = 1'b0;
        wait_for(1'b0, 1'b0, n);
        chk("A last high length", n, 1024);
        wait_for(1'b1, 1'b0, n);
        chk("A last low length", n, 1024);

        // B: cad_per=0 behaves as 1
        cad_per = 16'd0;
        en      = 1'b1;
        cycles(1);
        chk("B rev", rev_cnt, 3);
        wait_for(1'b0, 1'b0, n);
        chk("B high length", n, 512);
        en = 1'b0;
        wait_for(1'b1, 1'b0, n);
        chk("B low length", n, 512);

        // C: en dropped 100 clk into HIGH
        cad_per = 16'd1;
        en      = 1'b1;
        cycles(1);
        chk("C rev", rev_cnt, 4);
        cycles(100);
        en = 1'b0;
        wait_for(1'b0, 1'b0, n);
        chk("C rest of high", n, 412);
        wait_for(1'b1, 1'b0, n);
        chk("C low length", n, 512);
        cycles(600);
        chk("C idle busy", busy, 0);
        chk("C idle clean", cadence_clean, 0);
        chk("C idle rev", rev_cnt, 4);

        // D: cad_per 1 -> 3 mid-HIGH
        cad_per = 16'd1;
        en      = 1'b1;
        cycles(1);
        cycles(50);
        cad_per = 16'd3;
        wait_for(1'b0, 1'b0, n);
        chk("D rest of high", n, 462);
        wait_for(1'b0, 1'b1, n);
        chk("D low unaffected", n, 512);
        chk("D rev", rev_cnt, 6);
        en = 1'b0;
        wait_for(1'b0, 1'b0, n);
        chk("D new high length", n, 1536);
        wait_for(1'b1, 1'b0, n);
        chk("D new low length", n, 1536);

        // E: rev_cnt preset near the top, then wrap
        force dut.rev_cnt_q = 8'd254;
        cycles(1);
        release dut.rev_cnt_q;
        cycles(1);
        cad_per = 16'd0;
        en      = 1'b1;
        cycles(1);
        chk("E rev 255", rev_cnt, 255);
        wait_for(1'b0, 1'b0, n);
        wait_for(1'b0, 1'b1, n);
        chk("E rev wrap", rev_cnt, 0);
        chk("E no idle gap", n, 512);
        en = 1'b0;
        wait_for(1'b1, 1'b0, n);
        chk("E final revolution", n, 1024);
        cycles(600);

        // F: filter sees one transition per clean edge
        fwin    = 1'b1;
        cad_per = 16'd2;
        en      = 1'b1;
        cycles(1);
        chk("F rev", rev_cnt, 1);
        wait_for(1'b0, 1'b0, n);
        wait_for(1'b0, 1'b1, n);
        chk("F rev second", rev_cnt, 2);
        en = 1'b0;
        wait_for(1'b0, 1'b0, n);
        wait_for(1'b1, 1'b0, n);
        cycles(600);
        chk("F filter settled", filt, cadence_clean);
        chk("F filter after last edge", ftr, 1);
        fwin = 1'b0;

        // G: reset mid-LOW, then a fresh start
        cad_per = 16'd1;
        en      = 1'b1;
        cycles(1);
        chk("G rev before reset", rev_cnt, 3);
        wait_for(1'b0, 1'b0, n);
        cycles(100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("G async busy", busy, 0);
        chk("G async clean", cadence_clean, 0);
        chk("G async cadence", cadence, 0);
        chk("G async rev", rev_cnt, 0);
        cycles(3);
        chk("G held busy", busy, 0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        cycles(5);
        chk("G waits in idle", busy, 0);
        en = 1'b1;
        cycles(1);
        chk("G restart clean", cadence_clean, 1);
        chk("G restart rev", rev_cnt, 1);
        en = 1'b0;
        wait_for(1'b0, 1'b0, n);
        chk("G fresh high length", n, 512);
        wait_for(1'b1, 1'b0, n);
        chk("G low length", n, 512);
        cycles(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
